// File: rtl/sqrt_share_pkg.sv
// Shared types and helpers for the square-root core sharing arbiter.
package sqrt_share_pkg;

  typedef enum logic [1:0] {
    S_CLR,
    S_WARM,
    S_RUN
  } state_t;

  localparam int DEF_DW = 20;
  localparam int DEF_RW = 11;

  // Ceiling log2, never below 1 so a tag always has at least one bit
  function automatic int clog2(input int n);
    int r;
    r = 1;
    for (int i = 1; i < 32; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_arbiter_nreq.sv
// Combinational round-robin grant: search starts one past ptr, first valid wins.
module rr_arbiter_nreq
  import sqrt_share_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IW   = clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_valid,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] grant,
  output logic [IW-1:0]   grant_idx,
  output logic            grant_any
);

  logic [IW-1:0] idx;

  // Walk from lowest priority to highest so the highest-priority hit is written last
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    idx       = '0;
    for (int k = NREQ; k >= 1; k--) begin
      idx = IW'((int'(ptr) + k) % NREQ);
      if (req_valid[idx]) begin
        grant      = '0;
        grant[idx] = 1'b1;
        grant_idx  = idx;
        grant_any  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sqrt_share_arbiter.sv
// Shares one pipelined sqrt core between NREQ channels; a tag delay line routes results back.
// Optional SQRT_SHARE_ERRCHK_EN adds a sticky core handshake error flag (err_sticky).
module sqrt_share_arbiter
  import sqrt_share_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int DW   = DEF_DW,
  parameter int RW   = DEF_RW,
  parameter int LAT  = 16,
  parameter int HOLD = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]    req_ready,
  output logic [DW-1:0]      core_x_in,
  output logic               core_sclr,
  input  logic [RW-1:0]      core_x_out,
  input  logic               core_rdy,
  output logic [NREQ-1:0]    rsp_valid,
  output logic [RW-1:0]      rsp_data,
  output logic               busy
`ifdef SQRT_SHARE_ERRCHK_EN
  ,output logic              err_sticky
`endif
);

  localparam int IW   = clog2(NREQ);
  localparam int CMAX = (HOLD > LAT) ? HOLD : LAT;
  localparam int CW   = clog2(CMAX + 1);

  state_t          state_reg, state_next;
  logic [CW-1:0]   cnt_reg, cnt_next;
  logic [IW-1:0]   ptr_reg;
  logic [NREQ-1:0] grant;
  logic [IW-1:0]   grant_idx;
  logic            grant_any;
  logic            xfer;
  logic [DW-1:0]   operand;
  logic [LAT:0]    dl_valid_reg;
  logic [IW-1:0]   dl_tag_reg [LAT+1];
  logic [DW-1:0]   core_x_in_reg;
  logic            core_sclr_reg;
  logic [NREQ-1:0] rsp_valid_reg;
  logic [RW-1:0]   rsp_data_reg;
  logic            fire;

  rr_arbiter_nreq #(.NREQ(NREQ), .IW(IW)) u_arb (
    .req_valid (req_valid),
    .ptr       (ptr_reg),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_any (grant_any)
  );

  assign xfer      = (state_reg == S_RUN) && grant_any;
  assign req_ready = (state_reg == S_RUN) ? grant : '0;
  assign operand   = req_data[int'(grant_idx)*DW +: DW];

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      S_CLR: begin
        if (cnt_reg == CW'(HOLD - 1)) begin
          state_next = S_WARM;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      S_WARM: begin
        if (cnt_reg == CW'(LAT - 1)) begin
          state_next = S_RUN;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      default: cnt_next = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= S_CLR;
      cnt_reg       <= '0;
      ptr_reg       <= IW'(NREQ - 1);
      core_x_in_reg <= '0;
      core_sclr_reg <= 1'b1;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      if (xfer) ptr_reg <= grant_idx;
      core_x_in_reg <= xfer ? operand : '0;
      // Registered from next state so the clear lines up exactly with S_CLR
      core_sclr_reg <= (state_next == S_CLR);
    end
  end

  // Stage 0 is loaded on the same edge as core_x_in, so stage LAT meets core_x_out
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dl_valid_reg <= '0;
      for (int s = 0; s <= LAT; s++) dl_tag_reg[s] <= '0;
    end else begin
      dl_valid_reg  <= {dl_valid_reg[LAT-1:0], xfer};
      dl_tag_reg[0] <= xfer ? grant_idx : '0;
      for (int s = 1; s <= LAT; s++) dl_tag_reg[s] <= dl_tag_reg[s-1];
    end
  end

  assign fire = dl_valid_reg[LAT] && core_rdy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_reg <= '0;
      rsp_data_reg  <= '0;
    end else if (fire) begin
      rsp_valid_reg <= NREQ'(1) << dl_tag_reg[LAT];
      rsp_data_reg  <= core_x_out;
    end else begin
      rsp_valid_reg <= '0;
    end
  end

`ifdef SQRT_SHARE_ERRCHK_EN
  logic seen_first_reg;
  logic err_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seen_first_reg <= 1'b0;
      err_reg        <= 1'b0;
    end else begin
      if (fire) seen_first_reg <= 1'b1;
      if ((dl_valid_reg[LAT] && !core_rdy) ||
          ((state_reg == S_RUN) && core_rdy && !dl_valid_reg[LAT] && seen_first_reg))
        err_reg <= 1'b1;
    end
  end

  assign err_sticky = err_reg;
`endif

  assign core_x_in = core_x_in_reg;
  assign core_sclr = core_sclr_reg;
  assign rsp_valid = rsp_valid_reg;
  assign rsp_data  = rsp_data_reg;
  assign busy      = (|dl_valid_reg) || (|rsp_valid_reg);

endmodule

// File: tb/tb_sqrt_share_arbiter.sv
// Self-checking bench: behavioural sqrt core, grant table, and a response scoreboard.
module tb_sqrt_share_arbiter;

  localparam int NREQ = 4;
  localparam int DW   = 20;
  localparam int RW   = 11;
  localparam int LAT  = 16;
  localparam int HOLD = 2;

  logic               clk;
  logic               rst_n;
  logic [NREQ-1:0]    req_valid;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    req_ready;
  logic [DW-1:0]      core_x_in;
  logic               core_sclr;
  logic [RW-1:0]      core_x_out;
  logic               core_rdy;
  logic [NREQ-1:0]    rsp_valid;
  logic [RW-1:0]      rsp_data;
  logic               busy;
`ifdef SQRT_SHARE_ERRCHK_EN
  logic               err_sticky;
`endif

  sqrt_share_arbiter #(.NREQ(NREQ), .DW(DW), .RW(RW), .LAT(LAT), .HOLD(HOLD)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .core_x_in  (core_x_in),
    .core_sclr  (core_sclr),
    .core_x_out (core_x_out),
    .core_rdy   (core_rdy),
    .rsp_valid  (rsp_valid),
    .rsp_data   (rsp_data),
    .busy       (busy)
`ifdef SQRT_SHARE_ERRCHK_EN
    ,.err_sticky (err_sticky)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int n_rsp = 0;

  typedef struct {
    int ch;
    int val;
    int cyc;
  } exp_t;
  exp_t sbq[$];

  typedef struct {
    logic [NREQ-1:0]    valid;
    logic [NREQ*DW-1:0] data;
    logic [NREQ-1:0]    exp_ready;
  } vec_t;
  vec_t tbl[$];

  logic no_push;
  logic rdy_kill;
  logic xfer_seen;

  function automatic int isqrt(input int x);
    int r;
    r = 0;
    while ((r + 1) * (r + 1) <= x) r++;
    return r;
  endfunction

  function automatic logic [NREQ*DW-1:0] pack(input int a, input int b, input int c, input int d);
    return {DW'(d), DW'(c), DW'(b), DW'(a)};
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural core: LAT-stage sqrt pipeline, rdy tracks operands the bench saw accepted
  logic [RW-1:0]  x_pipe [LAT];
  logic [LAT-1:0] v_pipe;
  logic           v_in;

  always @(posedge clk) begin
    if (core_sclr || !rst_n) begin
      v_in   <= 1'b0;
      v_pipe <= '0;
      for (int i = 0; i < LAT; i++) x_pipe[i] <= '0;
    end else begin
      v_in      <= xfer_seen;
      v_pipe    <= {v_pipe[LAT-2:0], v_in};
      x_pipe[0] <= RW'(isqrt(int'(core_x_in)));
      for (int i = 1; i < LAT; i++) x_pipe[i] <= x_pipe[i-1];
    end
  end

  assign core_x_out = x_pipe[LAT-1];
  assign core_rdy   = v_pipe[LAT-1] & ~rdy_kill;

  always @(negedge clk) begin : mon
    logic [NREQ-1:0] x;
    logic [NREQ-1:0] one;
    exp_t e;
    x = req_valid & req_ready;
    xfer_seen = rst_n && (|x);
    if (rst_n) begin
      for (int i = 0; i < NREQ; i++) begin
        if (x[i] && !no_push) begin
          e.ch  = i;
          e.val = isqrt(int'(req_data[i*DW +: DW]));
          e.cyc = cyc + LAT + 2;
          sbq.push_back(e);
        end
      end
      if (rsp_valid != '0) begin
        n_rsp++;
        if (sbq.size() == 0) begin
          check("unexpected_rsp", int'(rsp_valid), 0);
        end else begin
          e = sbq.pop_front();
          one = '0;
          one[e.ch] = 1'b1;
          $display("rsp ch%0d data=%0d cycle=%0d", e.ch, rsp_data, cyc);
          check("rsp_valid", int'(rsp_valid), int'(one));
          check("rsp_data", int'(rsp_data), e.val);
          check("rsp_cycle", cyc, e.cyc);
        end
      end
    end
  end

  initial begin
    int c;
    int rsp_before;
    rst_n     = 1'b0;
    req_valid = '0;
    req_data  = '0;
    no_push   = 1'b0;
    rdy_kill  = 1'b0;
    xfer_seen = 1'b0;

    // Grant table, applied from the first S_RUN cycle with pointer at NREQ-1
    for (int r = 0; r < 8; r++)
      tbl.push_back('{4'b1111, pack(4, 9, 16, 25), 4'b0001 << (r % 4)});
    tbl.push_back('{4'b0100, pack(0, 0, 36, 0), 4'b0100});
    tbl.push_back('{4'b0100, pack(0, 0, 49, 0), 4'b0100});
    tbl.push_back('{4'b0100, pack(0, 0, 64, 0), 4'b0100});
    tbl.push_back('{4'b0100, pack(0, 0, 81, 0), 4'b0100});
    tbl.push_back('{4'b0100, pack(0, 0, 100, 0), 4'b0100});
    tbl.push_back('{4'b0010, pack(0, 400, 0, 0), 4'b0010});
    tbl.push_back('{4'b1000, pack(0, 0, 0, 1000000), 4'b1000});
    tbl.push_back('{4'b0000, pack(0, 0, 0, 0), 4'b0000});
    tbl.push_back('{4'b1001, pack(121, 0, 0, 144), 4'b0001});
    tbl.push_back('{4'b1001, pack(121, 0, 0, 144), 4'b1000});
    tbl.push_back('{4'b1010, pack(0, 169, 0, 196), 4'b0010});
    tbl.push_back('{4'b1010, pack(0, 169, 0, 196), 4'b1000});
    tbl.push_back('{4'b0110, pack(0, 225, 256, 0), 4'b0010});
    tbl.push_back('{4'b0110, pack(0, 225, 256, 0), 4'b0100});
    tbl.push_back('{4'b0000, pack(0, 0, 0, 0), 4'b0000});

    // Reset state
    repeat (3) tick();
    req_valid = 4'b1111;
    req_data  = pack(4, 9, 16, 25);
    #1;
    check("rst_req_ready", int'(req_ready), 0);
    check("rst_core_x_in", int'(core_x_in), 0);
    check("rst_core_sclr", int'(core_sclr), 1);
    check("rst_rsp_valid", int'(rsp_valid), 0);
    check("rst_rsp_data", int'(rsp_data), 0);
    check("rst_busy", int'(busy), 0);

    // Release: sclr for HOLD cycles, no grants until HOLD+LAT
    tick();
    rst_n = 1'b1;
    for (c = 0; c < HOLD + LAT; c++) begin
      #1;
      check("init_core_sclr", int'(core_sclr), (c < HOLD) ? 1 : 0);
      check("init_req_ready", int'(req_ready), 0);
      check("init_rsp_valid", int'(rsp_valid), 0);
      tick();
    end

    foreach (tbl[r]) begin
      req_valid = tbl[r].valid;
      req_data  = tbl[r].data;
      #1;
      check($sformatf("grant_row%0d", r), int'(req_ready), int'(tbl[r].exp_ready));
      tick();
    end
    req_valid = '0;
    #1;
    check("busy_in_flight", int'(busy), 1);
    repeat (LAT + 4) tick();
    check("drain_queue", sbq.size(), 0);
    check("busy_idle", int'(busy), 0);

`ifdef SQRT_SHARE_ERRCHK_EN
    check("err_clean", int'(err_sticky), 0);
    req_valid = 4'b0001;
    req_data  = pack(144, 0, 0, 0);
    no_push   = 1'b1;
    tick();
    req_valid = '0;
    no_push   = 1'b0;
    repeat (LAT) tick();
    rdy_kill = 1'b1;
    tick();
    rdy_kill = 1'b0;
    check("err_set", int'(err_sticky), 1);
    check("err_no_rsp", int'(rsp_valid), 0);
    repeat (3) tick();
    check("err_hold", int'(err_sticky), 1);
`endif

    // Reset mid-flight: three operations outstanding
    req_valid = 4'b1111;
    req_data  = pack(4, 9, 16, 25);
    repeat (3) tick();
    req_valid = '0;
    repeat (5) tick();
    rst_n = 1'b0;
    #1;
    check("mid_req_ready", int'(req_ready), 0);
    check("mid_core_x_in", int'(core_x_in), 0);
    check("mid_core_sclr", int'(core_sclr), 1);
    check("mid_rsp_valid", int'(rsp_valid), 0);
    check("mid_busy", int'(busy), 0);
`ifdef SQRT_SHARE_ERRCHK_EN
    check("mid_err", int'(err_sticky), 0);
`endif
    sbq.delete();
    rsp_before = n_rsp;
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (HOLD + LAT + LAT + 4) tick();
    check("mid_no_rsp", n_rsp, rsp_before);

    // One more operation after recovery
    req_valid = 4'b0100;
    req_data  = pack(0, 0, 81, 0);
    tick();
    req_valid = '0;
    repeat (LAT + 4) tick();
    check("post_rst_rsp", n_rsp, rsp_before + 1);
    check("post_rst_queue", sbq.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sqrt_share_arbiter.md
Name: sqrt_share_arbiter

Overview:
- Shares one fully pipelined 20-bit square-root core (x_in/x_out/rdy/clk/sclr) between NREQ acquisition channels, e.g. the per-channel RMS and magnitude paths.
- Round-robin arbitration issues at most one operand per cycle to the core.
- A valid/tag delay line matched to the core latency routes each result back to the channel that requested it.
- Also generates the core's synchronous clear from the block reset.

Parameters:
- NREQ, 4, number of requesters (2..8)
- DW, 20, operand width (core x_in)
- RW, 11, result width (core x_out)
- LAT, 16, core latency in clocks from x_in sampled to x_out valid
- HOLD, 2, cycles core_sclr stays high after rst_n deasserts

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  NREQ  per-channel operand valid
- req_data  in  NREQ*DW  packed operands, channel i at [i*DW +: DW]
- req_ready  out  NREQ  one-hot grant; transfer when req_valid[i] & req_ready[i]
- core_x_in  out  DW  operand to sqrt core (registered)
- core_sclr  out  1  synchronous clear to core (registered)
- core_x_out  in  RW  core result
- core_rdy  in  1  core result valid
- rsp_valid  out  NREQ  one-cycle pulse, result for channel i
- rsp_data  out  RW  result, valid with any rsp_valid bit
- busy  out  1  any operation in flight

Behaviour:
- Reset (async, rst_n=0) values:
  - req_ready=0, core_x_in=0, core_sclr=1, rsp_valid=0, rsp_data=0, busy=0.
  - Delay line cleared; round-robin pointer = NREQ-1, so channel 0 has first priority.
- FSM states:
  - S_CLR: core_sclr=1. Counts HOLD cycles after reset release, then goes to S_WARM.
  - S_WARM: core_sclr=0. Waits LAT cycles for the core pipeline to empty, then goes to S_RUN.
  - S_RUN: steady state; remains until reset.
  - req_ready=0 in every state except S_RUN.
- Arbitration (S_RUN only):
  - req_ready is combinational from req_valid and the pointer. Search starts at pointer+1 (mod NREQ); the first valid channel is granted. At most one bit is set.
  - On transfer: the pointer updates to the granted index, core_x_in <= operand, and a (valid=1, tag=index) entry enters the delay line.
  - Idle cycle: core_x_in <= 0 and a (valid=0) entry enters the delay line.
  - Never stalls; the full throughput is 1 operation/clock.
- Delay line: LAT+1 stages. Its output aligns with core_x_out for the operand registered into core_x_in.
- Response path:
  - When the delay-line output is valid and core_rdy=1: rsp_valid[tag] <= 1 and rsp_data <= core_x_out on the next edge.
  - Otherwise rsp_valid <= 0 and rsp_data holds.
- Latency: accepted in cycle T, rsp_valid high in cycle T+LAT+2.
- No response backpressure; requesters must sink rsp_valid.
- busy = OR of the delay-line valid bits, or rsp_valid non-zero.
- Boundaries:
  - A request held with no grant must keep its req_data stable.
  - Simultaneous requests from all channels are served strictly in rotating order.
  - A single active channel is granted every cycle.
  - Reset mid-flight discards all in-flight entries; no rsp_valid is produced for them.
  - Arithmetic is pass-through only; no width conversion.

Optional Feature:
- Macro: SQRT_SHARE_ERRCHK_EN.
- Enabled:
  - Adds output err_sticky (1 bit, reset 0).
  - Sets when the delay-line output is valid but core_rdy=0, or when core_rdy=1 in S_RUN with the delay-line output invalid after the first result.
  - Clears only on reset.
  - In the first case the result is dropped.
- Disabled: no port and no check logic; core_rdy gates responses only.

Decomposition:
- Package sqrt_share_pkg holds:
  - FSM state enum (S_CLR, S_WARM, S_RUN).
  - Default widths DW=20, RW=11.
  - Function clog2 for the tag width.
- Natural sub-module: rr_arbiter_nreq. Takes req_valid and pointer, returns one-hot grant plus encoded index. Purely combinational; the pointer register stays in the parent.

Test Plan:
- Reset release -> core_sclr high for 2 cycles; req_ready=0 until S_RUN (cycle 2+16 after release); no rsp_valid before.
- Channel 1 sends 400 in cycle T -> rsp_valid=4'b0010, rsp_data=20 in cycle T+18; channel 3 sends 1000000 -> rsp_data=1000.
- All four channels valid continuously for 8 cycles -> grants 0,1,2,3,0,1,2,3 one per cycle; responses appear in the same order, each with the correct per-channel value (operands 4, 9, 16, 25 -> 2, 3, 4, 5).
- Only channel 2 valid for 5 cycles -> granted 5 consecutive cycles; 5 back-to-back rsp_valid[2] pulses.
- rst_n asserted 5 cycles after issuing 3 operations -> all outputs at reset values immediately; zero responses after the new S_RUN entry.
- With SQRT_SHARE_ERRCHK_EN: force core_rdy=0 on an expected result -> err_sticky=1 next cycle, no rsp_valid pulse, flag holds until reset.
